// File: rtl/tile_loop_sequencer.sv
// tile_loop_sequencer
//   Walks the N (outer) / K (inner) tile loop of the GEMM accelerator without
//   host involvement. For every (n, k) it loads the input tile, starts the
//   core, loads the weight tile and waits for the core to finish. On the last
//   k it also drains the PPU output tile. TLAST is checked on every counted
//   beat and any mismatch is recorded in a sticky error flag.
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   i_start, i_k_tiles, i_n_tiles    launch pulse and loop bounds (0 -> 1)
//   o_busy, o_done                   run status / one-cycle completion pulse
//   o_dma_req/type/k/n, i_dma_ack    tile request handshake (type 1 = input)
//   i_in_beat, i_in_last             input/weight stream handshake and tlast
//   o_core_start, i_core_done        core launch pulse / compute-done pulse
//   o_acc_mode, o_out_en             core mode for the current tile
//   i_out_beat, i_out_last           PPU output stream handshake and tlast
//   o_cur_k, o_cur_n, o_err          loop position and sticky TLAST error
module tile_loop_sequencer #(
    parameter int CNT_W     = 8,
    parameter int BEAT_W    = 8,
    parameter int IN_BEATS  = 48,
    parameter int WT_BEATS  = 24,
    parameter int OUT_BEATS = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [CNT_W-1:0] i_k_tiles,
    input  logic [CNT_W-1:0] i_n_tiles,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_dma_req,
    output logic             o_dma_type,
    output logic [CNT_W-1:0] o_dma_k,
    output logic [CNT_W-1:0] o_dma_n,
    input  logic             i_dma_ack,
    input  logic             i_in_beat,
    input  logic             i_in_last,
    output logic             o_core_start,
    output logic             o_acc_mode,
    output logic             o_out_en,
    input  logic             i_core_done,
    input  logic             i_out_beat,
    input  logic             i_out_last,
    output logic [CNT_W-1:0] o_cur_k,
    output logic [CNT_W-1:0] o_cur_n,
    output logic             o_err
);
    typedef enum logic [3:0] {
        IDLE, IN_REQ, IN_LOAD, CORE_START, WT_REQ, WT_LOAD, WAIT_DONE, WAIT_OUT, NEXT
    } state_t;

    localparam logic [BEAT_W-1:0] IN_FINAL  = BEAT_W'(IN_BEATS - 1);
    localparam logic [BEAT_W-1:0] WT_FINAL  = BEAT_W'(WT_BEATS - 1);
    localparam logic [BEAT_W-1:0] OUT_FINAL = BEAT_W'(OUT_BEATS - 1);

    state_t            state;
    logic [CNT_W-1:0]  k, n, k_last, n_last;
    logic [BEAT_W-1:0] beat_cnt;
    logic              done_seen;

    // Beat source for the current data state; all zero outside data states
    // so stray beats are neither counted nor TLAST-checked.
    logic              beat;
    logic              beat_tlast;
    logic [BEAT_W-1:0] final_idx;
    logic              is_final;

    always_comb begin
        beat       = 1'b0;
        beat_tlast = 1'b0;
        final_idx  = '0;
        case (state)
            IN_LOAD:  begin beat = i_in_beat;  beat_tlast = i_in_last;  final_idx = IN_FINAL;  end
            WT_LOAD:  begin beat = i_in_beat;  beat_tlast = i_in_last;  final_idx = WT_FINAL;  end
            WAIT_OUT: begin beat = i_out_beat; beat_tlast = i_out_last; final_idx = OUT_FINAL; end
            default:  ;
        endcase
    end

    assign is_final = (beat_cnt == final_idx);
    assign o_cur_k  = k;
    assign o_cur_n  = n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            n            <= '0;
            k_last       <= '0;
            n_last       <= '0;
            beat_cnt     <= '0;
            done_seen    <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_dma_req    <= 1'b0;
            o_dma_type   <= 1'b0;
            o_dma_k      <= '0;
            o_dma_n      <= '0;
            o_core_start <= 1'b0;
            o_acc_mode   <= 1'b0;
            o_out_en     <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_done       <= 1'b0;
            o_core_start <= 1'b0;

            // Length is decided by the counter; tlast only feeds the error flag.
            if (beat && (beat_tlast != is_final))
                o_err <= 1'b1;

            // Core may finish before the weight tile is fully loaded.
            if (i_core_done && (state == CORE_START || state == WT_REQ || state == WT_LOAD))
                done_seen <= 1'b1;

            case (state)
                IDLE: if (i_start) begin
                    k_last     <= (i_k_tiles == '0) ? '0 : i_k_tiles - CNT_W'(1);
                    n_last     <= (i_n_tiles == '0) ? '0 : i_n_tiles - CNT_W'(1);
                    k          <= '0;
                    n          <= '0;
                    o_err      <= 1'b0;
                    done_seen  <= 1'b0;
                    o_busy     <= 1'b1;
                    o_dma_req  <= 1'b1;
                    o_dma_type <= 1'b1;
                    o_dma_k    <= '0;
                    o_dma_n    <= '0;
                    o_acc_mode <= 1'b0;
                    o_out_en   <= (i_k_tiles <= CNT_W'(1));
                    state      <= IN_REQ;
                end
                IN_REQ, WT_REQ: if (i_dma_ack) begin
                    o_dma_req <= 1'b0;
                    beat_cnt  <= '0;
                    state     <= (state == IN_REQ) ? IN_LOAD : WT_LOAD;
                end
                IN_LOAD: if (beat) begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                    if (is_final) begin
                        o_core_start <= 1'b1;
                        state        <= CORE_START;
                    end
                end
                CORE_START: begin
                    o_dma_req  <= 1'b1;
                    o_dma_type <= 1'b0;
                    o_dma_k    <= k;
                    o_dma_n    <= n;
                    state      <= WT_REQ;
                end
                WT_LOAD: if (beat) begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                    if (is_final)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: if (i_core_done || done_seen) begin
                    done_seen <= 1'b0;
                    beat_cnt  <= '0;
                    state     <= (k == k_last) ? WAIT_OUT : NEXT;
                end
                WAIT_OUT: if (beat) begin
                    beat_cnt <= beat_cnt + BEAT_W'(1);
                    if (is_final)
                        state <= NEXT;
                end
                NEXT: begin
                    if (k != k_last || n != n_last) begin
                        // Input buffer holds one tile, so every (n, k) reloads it.
                        o_dma_req  <= 1'b1;
                        o_dma_type <= 1'b1;
                        o_dma_n    <= '0;
                        state      <= IN_REQ;
                        if (k != k_last) begin
                            k          <= k + CNT_W'(1);
                            o_dma_k    <= k + CNT_W'(1);
                            o_acc_mode <= 1'b1;
                            o_out_en   <= ((k + CNT_W'(1)) == k_last);
                        end else begin
                            k          <= '0;
                            n          <= n + CNT_W'(1);
                            o_dma_k    <= '0;
                            o_acc_mode <= 1'b0;
                            o_out_en   <= (k_last == '0);
                        end
                    end else begin
                        o_done     <= 1'b1;
                        o_busy     <= 1'b0;
                        o_acc_mode <= 1'b0;
                        o_out_en   <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tile_loop_sequencer.sv
// Directed bench for tile_loop_sequencer: walks the tile loop acting as DMA,
// core and PPU, checking request fields, core mode, pulses and error flag.
module tb_tile_loop_sequencer;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             i_start;
    logic [CNT_W-1:0] i_k_tiles, i_n_tiles;
    logic             o_busy, o_done, o_dma_req, o_dma_type;
    logic [CNT_W-1:0] o_dma_k, o_dma_n;
    logic             i_dma_ack, i_in_beat, i_in_last;
    logic             o_core_start, o_acc_mode, o_out_en;
    logic             i_core_done, i_out_beat, i_out_last;
    logic [CNT_W-1:0] o_cur_k, o_cur_n;
    logic             o_err;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    tile_loop_sequencer dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_k_tiles(i_k_tiles), .i_n_tiles(i_n_tiles),
        .o_busy(o_busy), .o_done(o_done), .o_dma_req(o_dma_req), .o_dma_type(o_dma_type),
        .o_dma_k(o_dma_k), .o_dma_n(o_dma_n), .i_dma_ack(i_dma_ack), .i_in_beat(i_in_beat),
        .i_in_last(i_in_last), .o_core_start(o_core_start), .o_acc_mode(o_acc_mode),
        .o_out_en(o_out_en), .i_core_done(i_core_done), .i_out_beat(i_out_beat),
        .i_out_last(i_out_last), .o_cur_k(o_cur_k), .o_cur_n(o_cur_n), .o_err(o_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (o_done) done_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a request, hold it a couple of cycles, check fields, acknowledge.
    task automatic take_req(input logic typ, input int k, input int n, input int kt);
        int t = 0;
        while (!o_dma_req && t < 50) begin tick(); t++; end
        check("req_seen", {31'd0, o_dma_req}, 1);
        tick(); tick();
        check("req_held", {31'd0, o_dma_req}, 1);
        check("req_type", {31'd0, o_dma_type}, {31'd0, typ});
        check("req_k", {24'd0, o_dma_k}, k);
        check("req_n", {24'd0, o_dma_n}, typ ? 0 : n);
        check("acc_mode", {31'd0, o_acc_mode}, (k != 0) ? 1 : 0);
        check("out_en", {31'd0, o_out_en}, (k == kt - 1) ? 1 : 0);
        i_dma_ack = 1'b1;
        tick();
        i_dma_ack = 1'b0;
        check("req_drop", {31'd0, o_dma_req}, 0);
    endtask

    // Beats on the input/weight stream; core_done optionally pulsed on beat cd.
    task automatic in_beats(input int cnt, input int last_at, input int cd);
        for (int i = 0; i < cnt; i++) begin
            i_in_beat   = 1'b1;
            i_in_last   = (i == last_at);
            i_core_done = (i == cd);
            tick();
        end
        i_in_beat = 1'b0; i_in_last = 1'b0; i_core_done = 1'b0;
    endtask

    task automatic out_beats(input bit restart);
        for (int i = 0; i < 64; i++) begin
            i_out_beat = 1'b1;
            i_out_last = (i == 63);
            i_start    = restart && (i == 5);
            tick();
        end
        i_out_beat = 1'b0; i_out_last = 1'b0; i_start = 1'b0;
    endtask

    task automatic run_op(input int kin, input int nin, input int err_beat, input int cd_beat,
                          input bit restart, input bit exp_err);
        int kt = (kin == 0) ? 1 : kin;
        int nt = (nin == 0) ? 1 : nin;
        int d0 = done_cnt;
        i_k_tiles = CNT_W'(kin); i_n_tiles = CNT_W'(nin);
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        check("busy_launch", {31'd0, o_busy}, 1);
        check("err_cleared", {31'd0, o_err}, 0);
        check("req_latency", {31'd0, o_dma_req}, 1);
        for (int n = 0; n < nt; n++) begin
            for (int k = 0; k < kt; k++) begin
                bit first = (n == 0 && k == 0);
                take_req(1'b1, k, n, kt);
                in_beats(48, (first && err_beat >= 0) ? err_beat : 47, -1);
                check("core_start", {31'd0, o_core_start}, 1);
                tick();
                check("core_start_pulse", {31'd0, o_core_start}, 0);
                take_req(1'b0, k, n, kt);
                in_beats(24, 23, first ? cd_beat : -1);
                if (first && cd_beat >= 0) begin
                    tick();      // done_seen consumed, WAIT_DONE left
                end else begin
                    i_core_done = 1'b1;
                    tick();
                    i_core_done = 1'b0;
                end
                if (k == kt - 1) out_beats(restart);
                check("cur_k", {24'd0, o_cur_k}, k);
                check("cur_n", {24'd0, o_cur_n}, n);
                tick();          // NEXT resolved
                if (k == kt - 1 && n == nt - 1) begin
                    check("done_pulse", {31'd0, o_done}, 1);
                    check("busy_fall", {31'd0, o_busy}, 0);
                end else begin
                    check("next_req", {31'd0, o_dma_req}, 1);
                end
            end
        end
        tick();
        check("done_one_cycle", {31'd0, o_done}, 0);
        check("err_flag", {31'd0, o_err}, {31'd0, exp_err});
        repeat (5) tick();
        check("idle_no_req", {31'd0, o_dma_req}, 0);
        check("done_count", done_cnt - d0, 1);
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_k_tiles = '0; i_n_tiles = '0;
        i_dma_ack = 1'b0; i_in_beat = 1'b0; i_in_last = 1'b0;
        i_core_done = 1'b0; i_out_beat = 1'b0; i_out_last = 1'b0;
        repeat (3) tick();
        check("reset_outputs",
              {o_busy, o_done, o_dma_req, o_dma_type, o_dma_k, o_dma_n,
               o_core_start, o_acc_mode, o_out_en, o_cur_k, o_err}, 0);
        rst = 1'b0;
        tick();

        run_op(2, 2, -1, -1, 1'b0, 1'b0);   // full 2x2 loop
        run_op(0, 0, -1, -1, 1'b0, 1'b0);   // zero counts act as 1x1
        run_op(2, 1, -1, 10, 1'b0, 1'b0);   // early core_done during WT_LOAD
        run_op(1, 1, 20, -1, 1'b0, 1'b1);   // early input tlast
        run_op(1, 1, -1, -1, 1'b1, 1'b0);   // restart ignored during WAIT_OUT

        // Reset in the middle of a weight load.
        i_k_tiles = 8'd1; i_n_tiles = 8'd1;
        i_start = 1'b1; tick(); i_start = 1'b0;
        take_req(1'b1, 0, 0, 1);
        in_beats(48, 47, -1);
        tick();
        take_req(1'b0, 0, 0, 1);
        in_beats(10, -1, -1);
        rst = 1'b1;
        tick();
        check("mid_reset",
              {o_busy, o_done, o_dma_req, o_dma_type, o_dma_k, o_dma_n,
               o_core_start, o_acc_mode, o_out_en, o_cur_k, o_err}, 0);
        rst = 1'b0;
        tick();
        run_op(1, 2, -1, -1, 1'b0, 1'b0);   // clean run after reset

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
